// File: rtl/seg7_pkg.sv
// Shared seven-segment encoding: active-low gfedcba patterns and nibble codes.
// Both the scan driver and the scan capture import this so the tables match.
package seg7_pkg;

    localparam logic [6:0] SEG7_DIGITS [0:9] = '{
        7'b1000000,   // 0
        7'b1111001,   // 1
        7'b0100100,   // 2
        7'b0110000,   // 3
        7'b0011001,   // 4
        7'b0010010,   // 5
        7'b0000010,   // 6
        7'b1111000,   // 7
        7'b0000000,   // 8
        7'b0010000    // 9
    };

    localparam logic [6:0] SEG7_BLANK_PAT = 7'h7F;
    localparam logic [3:0] SEG7_BLANK     = 4'hF;
    localparam logic [3:0] SEG7_ERR       = 4'hE;

    // Position of the set bit in a one-hot byte (0 when none set).
    function automatic logic [2:0] onehot_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational decode of an active-low gfedcba pattern into a 4-bit code.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_code,
    output logic       o_blank,
    output logic       o_err
);

    // Table lookup; anything that is neither a digit nor blank is an error code.
    always_comb begin
        o_code = SEG7_ERR;
        if (i_seg == SEG7_BLANK_PAT) o_code = SEG7_BLANK;
        for (int d = 0; d < 10; d++) begin
            if (i_seg == SEG7_DIGITS[d]) o_code = 4'(d);
        end
        o_blank = (o_code == SEG7_BLANK);
        o_err   = (o_code == SEG7_ERR);
    end

endmodule

// File: rtl/seven_seg_scan_capture.sv
// Watches a multiplexed active-low seven-segment scan bus and rebuilds the
// displayed 8-digit frame, publishing it once it repeats STABLE_FRAMES times.
module seven_seg_scan_capture
    import seg7_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int STABLE_FRAMES  = 2,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg,
    input  logic [7:0]  an,
    output logic [31:0] digits,
    output logic [7:0]  blank_mask,
    output logic [7:0]  err_mask,
    output logic        frame_valid,
    output logic        scan_err,
    output logic        no_signal
);

    localparam int DW = $clog2(SETTLE_CYCLES + 1);
    localparam int SW = $clog2(STABLE_FRAMES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [6:0]  r_seg, r_seg_d;
    logic [7:0]  r_an, r_an_d;
    logic [DW-1:0] r_dwell;
    logic        r_sampled, r_multi_d;
    logic [TW-1:0] r_idle;
    logic [31:0] r_sh_dig, r_prev_dig, r_digits;
    logic [7:0]  r_sh_blank, r_sh_err, r_seen;
    logic [7:0]  r_prev_blank, r_prev_err, r_blank, r_err;
    logic        r_prev_valid, r_frame_valid, r_scan_err, r_no_signal;
    logic [SW-1:0] r_stable;

    logic        w_same, w_one_low, w_multi, w_sample, w_close, w_match;
    logic        w_publish, w_timeout, w_dblank, w_derr;
    logic [DW-1:0] w_dwell;
    logic [SW-1:0] w_stable_nxt;
    logic [2:0]  w_idx;
    logic [3:0]  w_code;
    logic [31:0] w_cl_dig;
    logic [7:0]  w_cl_blank, w_cl_err;

    seg7_decode u_decode (
        .i_seg   (r_seg),
        .o_code  (w_code),
        .o_blank (w_dblank),
        .o_err   (w_derr)
    );

    // Dwell length of the current pair (saturates at the sample point) and sample qualification.
    always_comb begin
        w_same    = (r_an == r_an_d) && (r_seg == r_seg_d);
        w_dwell   = '0;
        if (w_same) w_dwell = (r_dwell == DW'(SETTLE_CYCLES - 1)) ? r_dwell : r_dwell + DW'(1);
        w_one_low = $onehot(~r_an);
        w_multi   = (r_an != 8'hFF) && !w_one_low;
        w_sample  = w_one_low && !r_sampled && (w_dwell == DW'(SETTLE_CYCLES - 1));
        w_idx     = onehot_index(~r_an);
        w_close   = w_sample && (w_idx == 3'd0) && (r_seen != 8'h00);
        w_timeout = !w_sample && (r_idle == TW'(TIMEOUT_CYCLES - 1));
    end

    // Closed-frame view of the shadow, its comparison with the previous close and publish decision.
    always_comb begin
        w_cl_dig = '0;
        for (int i = 0; i < 8; i++) begin
            w_cl_dig[4*i +: 4] = r_seen[i] ? r_sh_dig[4*i +: 4] : SEG7_BLANK;
        end
        w_cl_blank   = ~r_seen | r_sh_blank;
        w_cl_err     = r_seen & r_sh_err;
        w_match      = r_prev_valid && (w_cl_dig == r_prev_dig) &&
                       (w_cl_blank == r_prev_blank) && (w_cl_err == r_prev_err);
        w_stable_nxt = SW'(1);
        if (w_match) w_stable_nxt = (r_stable == SW'(STABLE_FRAMES)) ? r_stable : r_stable + SW'(1);
        w_publish    = w_close && (w_stable_nxt >= SW'(STABLE_FRAMES));
    end

    // Input capture, dwell counter, one-sample-per-dwell flag and multi-low edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an       <= 8'hFF;
            r_an_d     <= 8'hFF;
            r_seg      <= SEG7_BLANK_PAT;
            r_seg_d    <= SEG7_BLANK_PAT;
            r_dwell    <= '0;
            r_sampled  <= 1'b0;
            r_multi_d  <= 1'b0;
            r_scan_err <= 1'b0;
        end else begin
            r_an       <= an;
            r_an_d     <= r_an;
            r_seg      <= seg;
            r_seg_d    <= r_seg;
            r_dwell    <= w_dwell;
            r_sampled  <= w_same && (r_sampled || w_sample);
            r_multi_d  <= w_multi;
            r_scan_err <= w_multi && !r_multi_d;
        end
    end

    // Shadow frame assembly, stability tracking, publication and loss-of-signal handling.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idle        <= '0;
            r_no_signal   <= 1'b1;
            r_sh_dig      <= '0;
            r_sh_blank    <= '0;
            r_sh_err      <= '0;
            r_seen        <= '0;
            r_prev_dig    <= '0;
            r_prev_blank  <= '0;
            r_prev_err    <= '0;
            r_prev_valid  <= 1'b0;
            r_stable      <= '0;
            r_digits      <= 32'hFFFF_FFFF;
            r_blank       <= 8'hFF;
            r_err         <= 8'h00;
            r_frame_valid <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            if (w_sample) begin
                r_idle      <= '0;
                r_no_signal <= 1'b0;
                if (w_close) begin
                    r_prev_dig   <= w_cl_dig;
                    r_prev_blank <= w_cl_blank;
                    r_prev_err   <= w_cl_err;
                    r_prev_valid <= 1'b1;
                    r_stable     <= w_stable_nxt;
                    if (w_publish) begin
                        r_digits      <= w_cl_dig;
                        r_blank       <= w_cl_blank;
                        r_err         <= w_cl_err;
                        r_frame_valid <= 1'b1;
                    end
                    r_sh_dig   <= {28'h0, w_code};
                    r_sh_blank <= {7'h0, w_dblank};
                    r_sh_err   <= {7'h0, w_derr};
                    r_seen     <= 8'h01;
                end else begin
                    r_sh_dig[{w_idx, 2'b00} +: 4] <= w_code;
                    r_sh_blank[w_idx]             <= w_dblank;
                    r_sh_err[w_idx]               <= w_derr;
                    r_seen[w_idx]                 <= 1'b1;
                end
            end else if (w_timeout) begin
                r_idle       <= TW'(TIMEOUT_CYCLES);
                r_no_signal  <= 1'b1;
                r_sh_dig     <= '0;
                r_sh_blank   <= '0;
                r_sh_err     <= '0;
                r_seen       <= '0;
                r_prev_dig   <= '0;
                r_prev_blank <= '0;
                r_prev_err   <= '0;
                r_prev_valid <= 1'b0;
                r_stable     <= '0;
                r_digits     <= 32'hFFFF_FFFF;
                r_blank      <= 8'hFF;
                r_err        <= 8'h00;
            end else if (r_idle != TW'(TIMEOUT_CYCLES)) begin
                r_idle <= r_idle + TW'(1);
            end
        end
    end

    assign digits      = r_digits;
    assign blank_mask  = r_blank;
    assign err_mask    = r_err;
    assign frame_valid = r_frame_valid;
    assign scan_err    = r_scan_err;
    assign no_signal   = r_no_signal;

endmodule

// File: tb/tb_seven_seg_scan_capture.sv
// Directed bench for seven_seg_scan_capture: table of scan scenarios plus
// hand-written sequences for latency, multi-low, glitch, timeout and reset.
module tb_seven_seg_scan_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic [31:0] digits;
    logic [7:0]  blank_mask, err_mask;
    logic        frame_valid, scan_err, no_signal;

    int n_checks = 0;
    int n_pass   = 0;
    int fv_cnt   = 0;
    int se_cnt   = 0;

    logic [6:0] pat [0:15];

    typedef struct {
        logic [31:0] codes;
        int          ndig;
        logic [31:0] exp_d;
        logic [7:0]  exp_b;
        logic [7:0]  exp_e;
    } vec_t;

    vec_t vt [5];

    always #5 clk = ~clk;

    seven_seg_scan_capture #(
        .SETTLE_CYCLES  (4),
        .STABLE_FRAMES  (2),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .seg         (seg),
        .an          (an),
        .digits      (digits),
        .blank_mask  (blank_mask),
        .err_mask    (err_mask),
        .frame_valid (frame_valid),
        .scan_err    (scan_err),
        .no_signal   (no_signal)
    );

    // Count pulse-high cycles away from the active edge.
    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (scan_err) se_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic hold(input logic [7:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Code nibble 0..9 -> digit, F -> blank, anything else -> an undecodable pattern.
    function automatic logic [55:0] mk(input logic [31:0] codes);
        logic [55:0] r;
        for (int i = 0; i < 8; i++) r[7*i +: 7] = pat[codes[4*i +: 4]];
        return r;
    endfunction

    task automatic scan_from(input logic [55:0] segs, input int first, input int last);
        for (int i = first; i <= last; i++) hold(~(8'h01 << i), segs[7*i +: 7], 8);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        an    = 8'hFF;
        seg   = 7'h7F;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [55:0] s1234, s0159;
        int c0, s0;

        pat[0]  = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100;
        pat[3]  = 7'b0110000; pat[4] = 7'b0011001; pat[5] = 7'b0010010;
        pat[6]  = 7'b0000010; pat[7] = 7'b1111000; pat[8] = 7'b0000000;
        pat[9]  = 7'b0010000; pat[10] = 7'b1010101; pat[11] = 7'b1010101;
        pat[12] = 7'b1010101; pat[13] = 7'b1010101; pat[14] = 7'b1010101;
        pat[15] = 7'b1111111;

        vt[0] = '{32'h0000_1234, 8, 32'h0000_1234, 8'h00, 8'h00};
        vt[1] = '{32'h0000_0159, 4, 32'hFFFF_0159, 8'hF0, 8'h00};
        vt[2] = '{32'h0000_1E34, 8, 32'h0000_1E34, 8'h00, 8'h04};
        vt[3] = '{32'h0000_6F87, 4, 32'hFFFF_6F87, 8'hF4, 8'h00};
        vt[4] = '{32'h0000_0078, 2, 32'hFFFF_FF78, 8'hFC, 8'h00};

        s1234 = mk(32'h0000_1234);
        s0159 = mk(32'h0000_0159);

        // Reset values
        do_reset;
        @(negedge clk);
        check("rst digits", digits, 32'hFFFF_FFFF);
        check("rst blank", {24'h0, blank_mask}, 32'hFF);
        check("rst err", {24'h0, err_mask}, 32'h0);
        check("rst fv", {31'h0, frame_valid}, 32'h0);
        check("rst scan_err", {31'h0, scan_err}, 32'h0);
        check("rst no_signal", {31'h0, no_signal}, 32'h1);
        @(posedge clk); #1;

        // Table-driven scan scenarios: three scans, publication on the third AN0
        for (int v = 0; v < 5; v++) begin
            do_reset;
            c0 = fv_cnt;
            scan_from(mk(vt[v].codes), 0, vt[v].ndig - 1);
            scan_from(mk(vt[v].codes), 0, vt[v].ndig - 1);
            check($sformatf("v%0d first close no pulse", v), fv_cnt - c0, 0);
            scan_from(mk(vt[v].codes), 0, vt[v].ndig - 1);
            check($sformatf("v%0d pulses", v), fv_cnt - c0, 1);
            check($sformatf("v%0d digits", v), digits, vt[v].exp_d);
            check($sformatf("v%0d blank", v), {24'h0, blank_mask}, {24'h0, vt[v].exp_b});
            check($sformatf("v%0d err", v), {24'h0, err_mask}, {24'h0, vt[v].exp_e});
        end

        // Exact latency of the publishing AN0 sample
        do_reset;
        scan_from(s1234, 0, 7);
        scan_from(s1234, 0, 7);
        an  = 8'hFE;
        seg = pat[4];
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("lat edge k+3 low", {31'h0, frame_valid}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("lat edge k+4 high", {31'h0, frame_valid}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        check("lat pulse width", {31'h0, frame_valid}, 32'h0);
        check("lat digits", digits, 32'h0000_1234);
        repeat (2) @(posedge clk);
        #1;
        scan_from(s1234, 1, 7);

        // Multi-anode-low mid-scan
        c0 = fv_cnt;
        s0 = se_cnt;
        scan_from(s1234, 0, 3);
        hold(8'hFC, pat[0], 10);
        scan_from(s1234, 4, 7);
        scan_from(s1234, 0, 1);
        check("multi scan_err cycles", se_cnt - s0, 1);
        check("multi fv pulses", fv_cnt - c0, 2);
        check("multi digits", digits, 32'h0000_1234);
        check("multi blank", {24'h0, blank_mask}, 32'h0);

        // Glitch rejection: 3-cycle dwells on AN1 are never sampled
        do_reset;
        c0 = fv_cnt;
        for (int j = 0; j < 10; j++) hold(8'hFD, (j % 2 == 1) ? pat[1] : pat[2], 3);
        check("glitch no_signal", {31'h0, no_signal}, 32'h1);
        check("glitch fv", fv_cnt - c0, 0);
        hold(8'hFD, pat[1], 8);
        check("settled sample no_signal", {31'h0, no_signal}, 32'h0);

        // Timeout after publication
        do_reset;
        scan_from(s1234, 0, 7);
        scan_from(s1234, 0, 7);
        scan_from(s1234, 0, 7);
        check("to pre digits", digits, 32'h0000_1234);
        hold(8'hFF, 7'h7F, 190);
        check("to not yet", {31'h0, no_signal}, 32'h0);
        hold(8'hFF, 7'h7F, 14);
        check("to no_signal", {31'h0, no_signal}, 32'h1);
        check("to digits", digits, 32'hFFFF_FFFF);
        check("to blank", {24'h0, blank_mask}, 32'hFF);
        check("to err", {24'h0, err_mask}, 32'h0);
        c0 = fv_cnt;
        scan_from(s1234, 0, 7);
        scan_from(s1234, 0, 7);
        check("to prev cleared", fv_cnt - c0, 0);

        // Reset mid-frame
        do_reset;
        scan_from(s1234, 0, 7);
        scan_from(s1234, 0, 7);
        scan_from(s1234, 0, 7);
        scan_from(s1234, 0, 2);
        do_reset;
        @(negedge clk);
        check("midrst digits", digits, 32'hFFFF_FFFF);
        check("midrst no_signal", {31'h0, no_signal}, 32'h1);
        @(posedge clk); #1;
        c0 = fv_cnt;
        scan_from(s1234, 0, 7);
        scan_from(s1234, 0, 7);
        check("midrst two scans", fv_cnt - c0, 0);
        scan_from(s1234, 0, 7);
        check("midrst third scan", fv_cnt - c0, 1);
        check("midrst digits after", digits, 32'h0000_1234);

        // Frame change reloads the stability count
        c0 = fv_cnt;
        scan_from(s0159, 0, 3);
        scan_from(s0159, 0, 3);
        check("chg first close", fv_cnt - c0, 1);
        check("chg digits held", digits, 32'h0000_1234);
        scan_from(s0159, 0, 3);
        check("chg second close", fv_cnt - c0, 2);
        check("chg digits new", digits, 32'hFFFF_0159);
        check("chg blank new", {24'h0, blank_mask}, 32'hF0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_capture.md
# seven_seg_scan_capture

Receive-side counterpart of the multiplexed 8-digit seven-segment driver. It watches the active-low `seg`/`an` scan bus, decodes each digit's segment pattern back to a 4-bit code and assembles complete 8-digit frames. It publishes a frame only after it is stable across scans. It sits on the board-level display bus (or a bench tap of it) and serves self-check, logging and loopback verification of the watch/timer display path.

## Interface
Parameters:
- `SETTLE_CYCLES`, 16: consecutive cycles an `an`/`seg` pair must be unchanged before it is sampled (≥2).
- `STABLE_FRAMES`, 2: consecutive identical closed frames required before publication (≥1).
- `TIMEOUT_CYCLES`, 2_000_000: cycles without any sample before declaring loss of signal.

Ports:
- `clk`, in, 1: system clock. One clock domain only.
- `reset`, in, 1: reset, synchronous, active-high.
- `seg`, in, 7: segment lines, active-low, bit order gfedcba.
- `an`, in, 8: anode enables, active-low; `an[i]` selects digit i.
- `digits`, out, 32: published frame; digit i is `[4i+3:4i]`. 0–9 decoded, 0xF blank/unseen, 0xE undecodable.
- `blank_mask`, out, 8: bit i set when digit i is blank or was not scanned in the frame.
- `err_mask`, out, 8: bit i set when digit i carried an undecodable pattern.
- `frame_valid`, out, 1: one-cycle pulse when `digits`/masks update.
- `scan_err`, out, 1: one-cycle pulse on first cycle of a multi-anode-low condition.
- `no_signal`, out, 1: high while no sample has occurred for `TIMEOUT_CYCLES`.

## Operation
- Inputs are registered once. All further logic uses the registered copies.
- **Dwell tracking:** a counter increments while the registered `an`/`seg` are equal to the previous cycle and clears on any change.
- **Sampling:**
  - A sample event occurs once per dwell, when the counter reaches `SETTLE_CYCLES-1` and exactly one `an` bit is low.
  - A sampled flag blocks further samples until `an` or `seg` changes.
  - `an` = 8'hFF: idle, no sample, not an error.
  - Two or more bits low: no sample, and `scan_err` pulses on the first such cycle.
- **Decode**, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - 1111111 gives 0xF (blank).
  - Anything else gives 0xE (error).
- **Shadow frame:** 8 nibbles plus a seen mask.
  - Each sample writes nibble i and sets seen bit i.
  - A repeat sample of the same index overwrites and is not an error.
- **Frame close:** occurs when a sample of index 0 arrives while the seen mask is nonzero.
  - Closed frame = shadow, with unseen digits forced to 0xF / blank.
  - The shadow is then cleared and the index-0 sample is written as the first entry of the new frame.
  - Partially scanned frames (e.g. set mode scanning AN0–AN3 only) are therefore legal.
- **Stability:**
  - On close, compare the frame (nibbles + masks) with the previous closed frame. `stable_cnt` increments (saturating) on a match; otherwise it loads 1.
  - When `stable_cnt ≥ STABLE_FRAMES`, copy the frame to the outputs and pulse `frame_valid`. This happens on every qualifying close, not only on change.
- **Timeout:** the idle counter clears on every sample. On reaching `TIMEOUT_CYCLES`:
  - `no_signal` goes to 1.
  - Outputs go to their reset values and `stable_cnt`, shadow and previous frame are cleared.
  - `no_signal` drops on the next sample.
- **Simultaneous events:** timeout and sample on the same cycle resolve to the sample (the counter clears).

## Timing
- Reset values: `digits` 32'hFFFF_FFFF, `blank_mask` 8'hFF, `err_mask` 0, `frame_valid` 0, `scan_err` 0, `no_signal` 1. All internal counters, shadow, seen mask, previous frame and `stable_cnt` are cleared.
- A reset mid-frame discards all partial state. The next publication needs `STABLE_FRAMES` fresh closes.
- Latency for a pair presented before edge k (registered at k):
  - Sample event at edge k+`SETTLE_CYCLES`-1.
  - For a closing index-0 sample, outputs update and `frame_valid` is high in the cycle after edge k+`SETTLE_CYCLES`.
- Dwells shorter than `SETTLE_CYCLES` cycles are never sampled. This is glitch rejection.
- `scan_err` lasts exactly one cycle per contiguous multi-low episode.

## Structure
- Shared package `seg7_pkg` holds:
  - The ten active-low digit patterns and the blank pattern 7'h7F.
  - Code constants `SEG7_BLANK`=4'hF and `SEG7_ERR`=4'hE.
- The driver side imports the same package, so encode and decode tables cannot diverge.
- One sub-module, `seg7_decode`: combinational 7-bit pattern to 4-bit code plus blank/err flags, instantiated once.
- The dwell counter, shadow frame, compare and timeout logic live in the top module.

## Test plan
Bench settings: `SETTLE_CYCLES`=4, `STABLE_FRAMES`=2, `TIMEOUT_CYCLES`=200, 8-cycle dwells per anode.
- Full scan: scan AN0..AN7 with 4,3,2,1,0,0,0,0 for three scans. The first close gives no pulse. At the AN0 of the third scan, `frame_valid` pulses once with `digits`=32'h0000_1234 and both masks 0.
- Partial scan: scan only AN0..AN3 with 9,5,1,0 for three scans. Expect `digits`=32'hFFFF_0159 and `blank_mask`=8'hF0.
- Undecodable pattern: drive `seg`=7'b1010101 on AN2 in the same scan. Expect nibble 2 = 0xE, `err_mask`=8'h04, others decoded.
- Multi-anode-low: hold `an`=8'b1111_1100 for 10 cycles mid-scan. Expect a single 1-cycle `scan_err` pulse, no sample, and the published frame unchanged.
- Glitch rejection: toggle `seg` every 3 cycles on AN1. Expect no sample and no `frame_valid`.
- Timeout and reset:
  - Hold `an`=8'hFF for 200 cycles after publication. Expect `no_signal`=1 and outputs at reset values.
  - Assert `reset` mid-frame. Expect reset values, and the next `frame_valid` only after 2 new closes.
